// File: rtl/light_pkg.sv
// Shared definitions for the running-light control and pattern stages:
// pattern-select encodings, default timing constants and the mode sequence.
package light_pkg;

    localparam int DB_CNT_DFLT   = 1_000_000;
    localparam int DIV_SLOW_DFLT = 25_000_000;
    localparam int DIV_FAST_DFLT = 6_250_000;

    localparam logic [1:0] MODE_ALT  = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_CONV = 2'b10;

    typedef enum logic [1:0] {
        ST_ALT  = 2'b00,
        ST_FILL = 2'b01,
        ST_CONV = 2'b10
    } mode_t;

    // Mode sequence; the unused 11 encoding falls back to ALT.
    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            ST_ALT:  next_mode = ST_FILL;
            ST_FILL: next_mode = ST_CONV;
            ST_CONV: next_mode = ST_ALT;
            default: next_mode = ST_ALT;
        endcase
    endfunction

endpackage

// File: rtl/light_mode_ctrl_if.sv
// Key inputs and pattern-stage control outputs of the light mode controller.
interface light_mode_ctrl_if;
    import light_pkg::*;

    logic       key_mode;
    logic       key_speed;
    logic [1:0] sel;
    logic       step;
    logic       pat_rst;
    logic       fast;

    modport master (
        output key_mode, key_speed,
        input  sel, step, pat_rst, fast
    );

    modport slave (
        input  key_mode, key_speed,
        output sel, step, pat_rst, fast
    );

endinterface

// File: rtl/key_debounce.sv
// One raw active-low push-button: 2-FF synchronizer, stability debounce and
// a single-cycle press pulse on the accepted 1->0 transition.
module key_debounce
    import light_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int             CW       = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CNT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, count stable cycles of a differing level, accept and flag presses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= sync2_r;
                // Only a released->pressed acceptance counts as an event.
                press_r <= level_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/light_mode_ctrl.sv
// Control stage for the running-light generator: pattern-select FSM, speed
// toggle, step-strobe divider and the pattern reset pulse.
module light_mode_ctrl
    import light_pkg::*;
#(
    parameter int DB_CNT   = DB_CNT_DFLT,
    parameter int DIV_SLOW = DIV_SLOW_DFLT,
    parameter int DIV_FAST = DIV_FAST_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    light_mode_ctrl_if.slave  bus
);

    localparam int            DW        = $clog2(DIV_SLOW);
    localparam logic [DW-1:0] SLOW_LAST = DW'(DIV_SLOW - 1);
    localparam logic [DW-1:0] FAST_LAST = DW'(DIV_FAST - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);

    mode_t         mode_r;
    logic          pat_rst_r;
    logic          init_r;
    logic          fast_r;
    logic          step_r;
    logic [DW-1:0] div_cnt_r;

    logic          mode_ev_s;
    logic          speed_ev_s;
    logic          clear_s;
    logic          wrap_s;
    logic [DW-1:0] div_last_s;

    key_debounce #(.DB_CNT(DB_CNT)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .key   (bus.key_mode),
        .press (mode_ev_s)
    );

    key_debounce #(.DB_CNT(DB_CNT)) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .key   (bus.key_speed),
        .press (speed_ev_s)
    );

    // Divider terminal count for the current speed and the shared clear condition.
    always_comb begin
        div_last_s = SLOW_LAST;
        if (fast_r) begin
            div_last_s = FAST_LAST;
        end else begin
            div_last_s = SLOW_LAST;
        end
        clear_s = mode_ev_s | speed_ev_s;
        wrap_s  = (div_cnt_r == div_last_s);
    end

    // Mode FSM; pat_rst is held through the first edge after reset and pulses on each mode change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r    <= ST_ALT;
            pat_rst_r <= 1'b1;
            init_r    <= 1'b0;
        end else begin
            init_r    <= 1'b1;
            pat_rst_r <= mode_ev_s | ~init_r;
            case (mode_r)
                ST_ALT, ST_FILL, ST_CONV: begin
                    if (mode_ev_s) begin
                        mode_r <= next_mode(mode_r);
                    end else begin
                        mode_r <= mode_r;
                    end
                end
                default: mode_r <= ST_ALT;
            endcase
        end
    end

    // Speed toggle and step divider; any key event restarts the step period from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fast_r    <= 1'b0;
            step_r    <= 1'b0;
            div_cnt_r <= {DW{1'b0}};
        end else begin
            if (speed_ev_s) begin
                fast_r <= ~fast_r;
            end else begin
                fast_r <= fast_r;
            end
            if (clear_s || wrap_s) begin
                div_cnt_r <= {DW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
            // A clear also lands on every pat_rst cycle, so step never coincides with it.
            step_r <= wrap_s & ~clear_s & init_r;
        end
    end

    assign bus.sel     = mode_r;
    assign bus.step    = step_r;
    assign bus.pat_rst = pat_rst_r;
    assign bus.fast    = fast_r;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Self-checking bench for light_mode_ctrl with short debounce and divider periods.
module tb_light_mode_ctrl;
    import light_pkg::*;

    localparam int DB = 4;
    localparam int DS = 8;
    localparam int DF = 2;

    typedef struct {
        logic [1:0] sel;
        logic       step;
        logic       pat_rst;
        logic       fast;
    } exp_t;

    typedef struct {
        logic       km;
        logic       ks;
        int         n;
        logic [1:0] sel;
        int         pats;
    } seg_t;

    logic clk;
    logic rst;
    light_mode_ctrl_if bus();

    light_mode_ctrl #(.DB_CNT(DB), .DIV_SLOW(DS), .DIV_FAST(DF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sbq[$];
    int   total;
    int   bad;
    int   seg_pats;
    int   seg_steps;

    // Reference model state: key delay lines, accepted levels, run lengths, pending events.
    logic       dl1[2];
    logic       dl2[2];
    logic       acc[2];
    logic       pend[2];
    int         run[2];
    logic [1:0] m_sel;
    logic       m_fast;
    logic       m_init;
    int         m_since;

    seg_t tbl[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            dl1[k]  = 1'b1;
            dl2[k]  = 1'b1;
            acc[k]  = 1'b1;
            pend[k] = 1'b0;
            run[k]  = 0;
        end
        m_sel   = MODE_ALT;
        m_fast  = 1'b0;
        m_init  = 1'b0;
        m_since = 0;
    endtask

    // Predicts the outputs visible just after the next rising edge.
    task automatic model_edge(input logic km, input logic ks, output exp_t e);
        logic ev_m;
        logic ev_s;
        logic raw;
        int   div;
        ev_m = pend[0];
        ev_s = pend[1];
        for (int k = 0; k < 2; k++) begin
            raw     = (k == 0) ? km : ks;
            pend[k] = 1'b0;
            if (dl2[k] != acc[k]) begin
                run[k]++;
                if (run[k] == DB) begin
                    pend[k] = acc[k];
                    acc[k]  = dl2[k];
                    run[k]  = 0;
                end
            end else begin
                run[k] = 0;
            end
            dl2[k] = dl1[k];
            dl1[k] = raw;
        end
        e.pat_rst = ev_m || !m_init;
        m_init    = 1'b1;
        if (ev_m) begin
            m_sel = (m_sel == MODE_ALT) ? MODE_FILL : (m_sel == MODE_FILL) ? MODE_CONV : MODE_ALT;
        end
        if (ev_s) m_fast = !m_fast;
        div = m_fast ? DF : DS;
        if (ev_m || ev_s) begin
            m_since = 0;
            e.step  = 1'b0;
        end else begin
            m_since++;
            e.step = ((m_since % div) == 0);
        end
        e.sel  = m_sel;
        e.fast = m_fast;
    endtask

    task automatic cyc(input logic km, input logic ks);
        exp_t e;
        bus.key_mode  = km;
        bus.key_speed = ks;
        model_edge(km, ks, e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        total++;
        if ({bus.sel, bus.step, bus.pat_rst, bus.fast} !== {e.sel, e.step, e.pat_rst, e.fast}) begin
            bad++;
            $display("FAIL cycle@%0t sel/step/pat_rst/fast: got %b/%b/%b/%b expected %b/%b/%b/%b",
                     $time, bus.sel, bus.step, bus.pat_rst, bus.fast,
                     e.sel, e.step, e.pat_rst, e.fast);
        end
        if (bus.pat_rst) seg_pats++;
        if (bus.step) seg_steps++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.key_mode  = 1'b1;
        bus.key_speed = 1'b1;
        model_reset();

        tbl[0]  = '{1'b1, 1'b1, 24, MODE_ALT,  1};
        tbl[1]  = '{1'b0, 1'b1, 20, MODE_FILL, 1};
        tbl[2]  = '{1'b1, 1'b1, 12, MODE_FILL, 0};
        tbl[3]  = '{1'b0, 1'b1, 10, MODE_CONV, 1};
        tbl[4]  = '{1'b1, 1'b1, 10, MODE_CONV, 0};
        tbl[5]  = '{1'b0, 1'b1, 10, MODE_ALT,  1};
        tbl[6]  = '{1'b1, 1'b1, 10, MODE_ALT,  0};
        tbl[7]  = '{1'b0, 1'b1, 10, MODE_FILL, 1};
        tbl[8]  = '{1'b1, 1'b1, 10, MODE_FILL, 0};
        tbl[9]  = '{1'b0, 1'b1, 2,  MODE_FILL, 0};
        tbl[10] = '{1'b1, 1'b1, 1,  MODE_FILL, 0};
        tbl[11] = '{1'b0, 1'b1, 2,  MODE_FILL, 0};
        tbl[12] = '{1'b1, 1'b1, 10, MODE_FILL, 0};
        tbl[13] = '{1'b0, 1'b1, 10, MODE_CONV, 1};
        tbl[14] = '{1'b1, 1'b1, 10, MODE_CONV, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", bus.sel, 0);
        chk("reset_step", bus.step, 0);
        chk("reset_pat_rst", bus.pat_rst, 1);
        chk("reset_fast", bus.fast, 0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            seg_pats = 0;
            repeat (tbl[i].n) cyc(tbl[i].km, tbl[i].ks);
            chk($sformatf("seg%0d_sel", i), bus.sel, tbl[i].sel);
            chk($sformatf("seg%0d_pat_pulses", i), seg_pats, tbl[i].pats);
        end

        // Speed press timed so the event lands while div_cnt is 6.
        for (int i = 0; i < DS && ((m_since + DB + 2) % DS) != 6; i++) cyc(1'b1, 1'b1);
        seg_pats = 0;
        repeat (10) cyc(1'b1, 1'b0);
        chk("speed1_fast", bus.fast, 1);
        chk("speed1_no_pat_rst", seg_pats, 0);
        repeat (10) cyc(1'b1, 1'b1);
        seg_steps = 0;
        repeat (8) cyc(1'b1, 1'b1);
        chk("fast_steps_in_8", seg_steps, 4);
        repeat (10) cyc(1'b1, 1'b0);
        chk("speed2_fast", bus.fast, 0);
        repeat (10) cyc(1'b1, 1'b1);
        seg_steps = 0;
        repeat (16) cyc(1'b1, 1'b1);
        chk("slow_steps_in_16", seg_steps, 2);

        // Both keys together: one pat_rst pulse, sel advances, fast toggles.
        seg_pats = 0;
        repeat (10) cyc(1'b0, 1'b0);
        chk("both_sel", bus.sel, MODE_ALT);
        chk("both_fast", bus.fast, 1);
        chk("both_pat_pulses", seg_pats, 1);
        repeat (10) cyc(1'b1, 1'b1);
        repeat (10) cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b1, 1'b1);
        chk("pre_rst_sel", bus.sel, MODE_FILL);

        // Asynchronous reset in the middle of a cycle.
        repeat (3) cyc(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_sel", bus.sel, 0);
        chk("midrst_pat_rst", bus.pat_rst, 1);
        chk("midrst_step", bus.step, 0);
        chk("midrst_fast", bus.fast, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) cyc(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
